// File: rtl/mem_arbiter.sv
// Three-way PSRAM arbiter (VIC, CPU, DMA) issuing single-byte commands to a memory controller.
// VIC has priority with a bounded run; CPU and DMA share round-robin; busy handshake with timeout.
module mem_arbiter #(
  parameter int BUSY_TIMEOUT = 8,
  parameter int VIC_MAX_RUN  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vic_req,
  input  logic        cpu_req,
  input  logic        dma_req,
  input  logic [15:0] vic_addr,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] dma_addr,
  input  logic [6:0]  vic_bank,
  input  logic [6:0]  cpu_bank,
  input  logic [6:0]  dma_bank,
  input  logic        cpu_we,
  input  logic        dma_we,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  dma_wdata,
  output logic        vic_ack,
  output logic        cpu_ack,
  output logic        dma_ack,
  output logic [7:0]  rdata,
  output logic        mc_ce,
  output logic        mc_write,
  output logic [6:0]  mc_bank,
  output logic [15:0] mc_addr,
  output logic [7:0]  mc_wdata,
  output logic [3:0]  mc_nbytes,
  input  logic        mc_busy,
  input  logic [7:0]  mc_rdata,
  output logic        timeout_err
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_ACK} state_t;

  localparam int RUN_W = $clog2(VIC_MAX_RUN + 1);
  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [1:0] OWN_VIC = 2'd0;
  localparam logic [1:0] OWN_CPU = 2'd1;
  localparam logic [1:0] OWN_DMA = 2'd2;

  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [RUN_W-1:0] vic_run_q, vic_run_d;
  logic             rr_cpu_q, rr_cpu_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             write_q, write_d;
  logic [6:0]       bank_q, bank_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             timeout_q, timeout_d;

  logic others_pend, vic_starved, grant_any, grant_vic, grant_cpu, grant_dma, tmo_hit;

  assign others_pend = cpu_req | dma_req;
  assign vic_starved = others_pend && (vic_run_q >= RUN_W'(VIC_MAX_RUN));
  assign grant_any   = (state_q == S_IDLE) && !mc_busy && (vic_req || others_pend);
  assign grant_vic   = grant_any && vic_req && !vic_starved;
  // rr_cpu_q set means CPU wins a CPU/DMA tie
  assign grant_cpu   = grant_any && !grant_vic && cpu_req && (!dma_req || rr_cpu_q);
  assign grant_dma   = grant_any && !grant_vic && !grant_cpu;
  assign tmo_hit     = (state_q == S_WAIT_BUSY) && !mc_busy && (tmo_q == TMO_W'(BUSY_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_VIC;
      vic_run_q <= '0;
      rr_cpu_q  <= 1'b1;
      tmo_q     <= '0;
      write_q   <= 1'b0;
      bank_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      vic_run_q <= vic_run_d;
      rr_cpu_q  <= rr_cpu_d;
      tmo_q     <= tmo_d;
      write_q   <= write_d;
      bank_q    <= bank_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (grant_any) state_d = S_ISSUE;
      S_ISSUE:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (mc_busy) state_d = S_WAIT_DONE;
                   else if (tmo_hit) state_d = S_ACK;
      S_WAIT_DONE: if (!mc_busy) state_d = S_ACK;
      S_ACK:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    owner_d   = owner_q;
    vic_run_d = vic_run_q;
    rr_cpu_d  = rr_cpu_q;
    tmo_d     = '0;
    write_d   = write_q;
    bank_d    = bank_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;
    if (state_q == S_IDLE && !others_pend) vic_run_d = '0;
    if (grant_vic) begin
      owner_d   = OWN_VIC;
      addr_d    = vic_addr;
      bank_d    = vic_bank;
      write_d   = 1'b0;
      wdata_d   = '0;
      vic_run_d = others_pend ? vic_run_q + RUN_W'(1) : '0;
    end else if (grant_cpu) begin
      owner_d   = OWN_CPU;
      addr_d    = cpu_addr;
      bank_d    = cpu_bank;
      write_d   = cpu_we;
      wdata_d   = cpu_wdata;
      vic_run_d = '0;
      rr_cpu_d  = 1'b0;
    end else if (grant_dma) begin
      owner_d   = OWN_DMA;
      addr_d    = dma_addr;
      bank_d    = dma_bank;
      write_d   = dma_we;
      wdata_d   = dma_wdata;
      vic_run_d = '0;
      rr_cpu_d  = 1'b1;
    end
    if (state_q == S_WAIT_BUSY && !mc_busy) tmo_d = tmo_q + TMO_W'(1);
    if (tmo_hit) timeout_d = 1'b1;
    if (state_q == S_WAIT_DONE && !mc_busy && !write_q) rdata_d = mc_rdata;
  end

  always_comb begin
    mc_ce   = (state_q == S_ISSUE);
    vic_ack = (state_q == S_ACK) && (owner_q == OWN_VIC);
    cpu_ack = (state_q == S_ACK) && (owner_q == OWN_CPU);
    dma_ack = (state_q == S_ACK) && (owner_q == OWN_DMA);
  end

  assign mc_write    = write_q;
  assign mc_bank     = bank_q;
  assign mc_addr     = addr_q;
  assign mc_wdata    = wdata_q;
  assign mc_nbytes   = 4'd1;
  assign rdata       = rdata_q;
  assign timeout_err = timeout_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single-requester transactions against a behavioural
// controller, plus hand sequences for arbitration order, timeout, init-busy and reset abort.
module tb_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        vic_req = 0, cpu_req = 0, dma_req = 0;
  logic [15:0] vic_addr = 0, cpu_addr = 0, dma_addr = 0;
  logic [6:0]  vic_bank = 0, cpu_bank = 0, dma_bank = 0;
  logic        cpu_we = 0, dma_we = 0;
  logic [7:0]  cpu_wdata = 0, dma_wdata = 0;
  logic        vic_ack, cpu_ack, dma_ack;
  logic [7:0]  rdata;
  logic        mc_ce, mc_write;
  logic [6:0]  mc_bank;
  logic [15:0] mc_addr;
  logic [7:0]  mc_wdata;
  logic [3:0]  mc_nbytes;
  logic        mc_busy;
  logic [7:0]  mc_rdata;
  logic        timeout_err;

  mem_arbiter #(.BUSY_TIMEOUT(8), .VIC_MAX_RUN(4)) dut (
    .clk(clk), .reset(reset),
    .vic_req(vic_req), .cpu_req(cpu_req), .dma_req(dma_req),
    .vic_addr(vic_addr), .cpu_addr(cpu_addr), .dma_addr(dma_addr),
    .vic_bank(vic_bank), .cpu_bank(cpu_bank), .dma_bank(dma_bank),
    .cpu_we(cpu_we), .dma_we(dma_we),
    .cpu_wdata(cpu_wdata), .dma_wdata(dma_wdata),
    .vic_ack(vic_ack), .cpu_ack(cpu_ack), .dma_ack(dma_ack),
    .rdata(rdata), .mc_ce(mc_ce), .mc_write(mc_write), .mc_bank(mc_bank),
    .mc_addr(mc_addr), .mc_wdata(mc_wdata), .mc_nbytes(mc_nbytes),
    .mc_busy(mc_busy), .mc_rdata(mc_rdata), .timeout_err(timeout_err)
  );

  // Behavioural controller: busy for ctl_len cycles after each mc_ce unless ctl_never.
  int         busy_left = 0;
  logic       busy_force = 1'b0;
  logic       ctl_never = 1'b0;
  int         ctl_len = 1;
  logic [7:0] ctl_data = 8'h00;
  always @(posedge clk) begin
    if (mc_ce && !ctl_never) busy_left <= ctl_len;
    else if (busy_left > 0)  busy_left <= busy_left - 1;
  end
  assign mc_busy  = busy_force || (busy_left > 0);
  assign mc_rdata = ctl_data;

  int ce_count = 0;
  int multi_ack = 0;
  always @(negedge clk) begin
    if (mc_ce) ce_count <= ce_count + 1;
    if ((int'(vic_ack) + int'(cpu_ack) + int'(dma_ack)) > 1) multi_ack <= multi_ack + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    vic_req = 0; cpu_req = 0; dma_req = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  // Returns owner (0 VIC, 1 CPU, 2 DMA) and the number of clock edges waited.
  task automatic wait_ack(input int budget, output int owner, output int cycles);
    owner = -1;
    cycles = 0;
    while (owner < 0 && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (vic_ack) owner = 0;
      else if (cpu_ack) owner = 1;
      else if (dma_ack) owner = 2;
    end
    if (owner < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_wait: no ack within %0d cycles", budget);
    end
  endtask

  typedef struct {
    int          src;
    logic        we;
    logic [15:0] addr;
    logic [6:0]  bank;
    logic [7:0]  wdata;
    int          blen;
    logic [7:0]  mdata;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[6];
  int   exp_ord3[10];
  int   exp_ord2[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int owner, cyc, ce0, acks, got;
    logic prev_busy;
    logic [7:0] rd_before;
    vec_t v;

    vecs[0] = '{1, 1'b0, 16'h1234, 7'h02, 8'h00, 6, 8'hA5, 8'hA5};
    vecs[1] = '{2, 1'b1, 16'hBEEF, 7'h7F, 8'h5A, 3, 8'h11, 8'hA5};
    vecs[2] = '{0, 1'b0, 16'h0001, 7'h40, 8'h00, 1, 8'hC3, 8'hC3};
    vecs[3] = '{1, 1'b1, 16'hFFFF, 7'h01, 8'hFF, 2, 8'h00, 8'hC3};
    vecs[4] = '{2, 1'b0, 16'h8000, 7'h3F, 8'h00, 4, 8'h7E, 8'h7E};
    vecs[5] = '{0, 1'b0, 16'h0000, 7'h00, 8'h00, 2, 8'h00, 8'h00};
    exp_ord3 = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};
    exp_ord2 = '{1, 2, 1, 2};

    // Reset values
    do_reset();
    check("rst_mc_ce", mc_ce, 0);
    check("rst_acks", {vic_ack, cpu_ack, dma_ack}, 0);
    check("rst_mc_addr", mc_addr, 0);
    check("rst_mc_write", mc_write, 0);
    check("rst_mc_nbytes", mc_nbytes, 1);
    check("rst_rdata", rdata, 0);
    check("rst_timeout", timeout_err, 0);

    // Controller busy after reset blocks grants for 50 cycles
    reset = 1'b0;
    busy_force = 1'b1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0042; cpu_bank = 7'h05;
    ctl_len = 2; ctl_data = 8'h5A;
    @(negedge clk);
    reset = 1'b1;
    ce0 = ce_count;
    acks = 0;
    repeat (50) begin
      @(negedge clk);
      if (mc_ce) acks++;
    end
    check("init_busy_no_ce", acks, 0);
    check("init_busy_no_err", timeout_err, 0);
    busy_force = 1'b0;
    @(negedge clk);
    check("init_busy_ce_next", mc_ce, 1);
    wait_ack(40, owner, cyc);
    check("init_busy_owner", owner, 1);
    check("init_busy_rdata", rdata, 8'h5A);
    $display("[TB] txn init-busy owner=%0d rdata=%0h", owner, rdata);
    cpu_req = 0;
    @(negedge clk);

    // Table of single-requester transactions
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      ctl_len = v.blen;
      ctl_data = v.mdata;
      ce0 = ce_count;
      vic_addr = ~v.addr; cpu_addr = ~v.addr; dma_addr = ~v.addr;
      vic_bank = ~v.bank; cpu_bank = ~v.bank; dma_bank = ~v.bank;
      cpu_we = ~v.we; dma_we = ~v.we;
      cpu_wdata = ~v.wdata; dma_wdata = ~v.wdata;
      case (v.src)
        0: begin vic_addr = v.addr; vic_bank = v.bank; vic_req = 1; end
        1: begin cpu_addr = v.addr; cpu_bank = v.bank; cpu_we = v.we; cpu_wdata = v.wdata; cpu_req = 1; end
        default: begin dma_addr = v.addr; dma_bank = v.bank; dma_we = v.we; dma_wdata = v.wdata; dma_req = 1; end
      endcase
      wait_ack(50, owner, cyc);
      check($sformatf("v%0d_owner", i), owner, v.src);
      check($sformatf("v%0d_latency", i), cyc, v.blen + 3);
      check($sformatf("v%0d_addr", i), mc_addr, v.addr);
      check($sformatf("v%0d_bank", i), mc_bank, v.bank);
      check($sformatf("v%0d_write", i), mc_write, v.we);
      check($sformatf("v%0d_wdata", i), mc_wdata, v.wdata);
      check($sformatf("v%0d_nbytes", i), mc_nbytes, 1);
      check($sformatf("v%0d_rdata", i), rdata, v.exp_rdata);
      check($sformatf("v%0d_ce_count", i), ce_count - ce0, 1);
      vic_req = 0; cpu_req = 0; dma_req = 0;
      @(negedge clk);
      check($sformatf("v%0d_ack_pulse", i), {vic_ack, cpu_ack, dma_ack}, 0);
      $display("[TB] txn vec%0d src=%0d addr=%0h we=%0d rdata=%0h cycles=%0d", i, owner, mc_addr, mc_write, rdata, cyc);
    end

    // All three requesting: bounded VIC run
    do_reset();
    ctl_len = 1; ctl_data = 8'h00;
    cpu_we = 0; dma_we = 0;
    vic_req = 1; cpu_req = 1; dma_req = 1;
    for (int k = 0; k < 10; k++) begin
      wait_ack(30, owner, cyc);
      check($sformatf("order3_%0d", k), owner, exp_ord3[k]);
      $display("[TB] txn order3 #%0d owner=%0d", k, owner);
    end
    vic_req = 0; cpu_req = 0; dma_req = 0;
    repeat (2) @(negedge clk);

    // CPU and DMA only: alternation starting with CPU
    do_reset();
    ctl_len = 1; ctl_data = 8'h99;
    cpu_we = 0; dma_we = 0;
    cpu_req = 1; dma_req = 1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(30, owner, cyc);
      check($sformatf("order2_%0d", k), owner, exp_ord2[k]);
      $display("[TB] txn order2 #%0d owner=%0d", k, owner);
    end
    cpu_req = 0; dma_req = 0;
    repeat (2) @(negedge clk);

    // DMA write with controller that never answers
    rd_before = rdata;
    check("tmo_rdata_pre", rd_before, 8'h99);
    ctl_never = 1'b1;
    dma_req = 1; dma_we = 1; dma_wdata = 8'h3C; dma_addr = 16'h0BAD; dma_bank = 7'h11;
    wait_ack(40, owner, cyc);
    check("tmo_owner", owner, 2);
    check("tmo_latency", cyc, 10);
    check("tmo_err", timeout_err, 1);
    check("tmo_rdata_kept", rdata, rd_before);
    check("tmo_wdata", mc_wdata, 8'h3C);
    $display("[TB] txn timeout owner=%0d err=%0d cycles=%0d", owner, timeout_err, cyc);
    dma_req = 0;
    ctl_never = 1'b0;
    ctl_len = 2; ctl_data = 8'h66;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0777;
    wait_ack(30, owner, cyc);
    check("tmo_next_owner", owner, 1);
    check("tmo_sticky", timeout_err, 1);
    cpu_req = 0;
    do_reset();
    check("tmo_cleared", timeout_err, 0);

    // Reset during WAIT_DONE abandons the transaction
    ctl_len = 20; ctl_data = 8'h77;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h2468; cpu_bank = 7'h33;
    repeat (4) @(negedge clk);
    check("abort_busy", mc_busy, 1);
    reset = 1'b0;
    cpu_req = 0;
    @(negedge clk);
    check("abort_ce", mc_ce, 0);
    check("abort_acks", {vic_ack, cpu_ack, dma_ack}, 0);
    check("abort_addr", mc_addr, 0);
    check("abort_bank", mc_bank, 0);
    check("abort_rdata", rdata, 0);
    check("abort_nbytes", mc_nbytes, 1);
    reset = 1'b1;
    ctl_len = 2;
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (vic_ack || cpu_ack || dma_ack) acks++;
    end
    check("abort_no_ack", acks, 0);
    cpu_req = 1; cpu_addr = 16'h4242;
    prev_busy = mc_busy;
    got = 0;
    for (int c = 0; c < 60 && got == 0; c++) begin
      @(negedge clk);
      if (mc_ce) begin
        check("abort_ce_after_idle", prev_busy, 0);
        got = 1;
      end
      prev_busy = mc_busy;
    end
    check("abort_regrant", got, 1);
    wait_ack(30, owner, cyc);
    check("abort_owner", owner, 1);
    check("abort_rdata_new", rdata, 8'h77);
    $display("[TB] txn post-abort owner=%0d addr=%0h rdata=%0h", owner, mc_addr, rdata);
    cpu_req = 0;
    repeat (2) @(negedge clk);

    check("single_ack", multi_ack, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
